// File: rtl/binary_divider.sv
// binary_divider: sequential unsigned restoring divider.
//   Resolves one quotient bit per clock using a start/busy/done handshake.
//   A zero divisor returns without any iteration cycles. The quotient is all
//   ones, the remainder is the low dividend bits, and div_zero_o is set.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      request a division; sampled only while idle
//   dividend_i   unsigned dividend, N_DVD bits; captured on accept
//   divisor_i    unsigned divisor, N_DVS bits; captured on accept
//   quotient_o   registered quotient, N_DVD bits
//   remainder_o  registered remainder, N_DVS bits
//   busy_o       high while iterations are in progress
//   done_o       one-cycle pulse when a new result is presented
//   div_zero_o   latest result came from a zero divisor; held with the result
module binary_divider #(
  parameter int unsigned N_DVD = 8,
  parameter int unsigned N_DVS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [N_DVD-1:0] dividend_i,
  input  logic [N_DVS-1:0] divisor_i,
  output logic [N_DVD-1:0] quotient_o,
  output logic [N_DVS-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CntW = (N_DVD > 1) ? $clog2(N_DVD) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [N_DVS-1:0] dvs_q;
  logic [N_DVD-1:0] shift_q;   // dividend bits shift out, quotient bits shift in
  logic [N_DVS:0]   p_q;       // partial remainder, one bit wider than the divisor
  logic [CntW-1:0]  cnt_q;
  logic [N_DVD-1:0] quotient_q;
  logic [N_DVS-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;

  // One restoring step, computed from the current iteration state.
  logic [N_DVS:0]   p_shift;
  logic             p_ge;
  logic [N_DVS:0]   p_d;
  logic [N_DVD-1:0] shift_d;
  logic             last_iter;

  always_comb begin
    p_shift   = {p_q[N_DVS-1:0], shift_q[N_DVD-1]};
    p_ge      = (p_shift >= {1'b0, dvs_q});
    p_d       = p_ge ? (p_shift - {1'b0, dvs_q}) : p_shift;
    shift_d   = {shift_q[N_DVD-2:0], p_ge};
    last_iter = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvs_q       <= '0;
      shift_q     <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (divisor_i != '0) begin
              dvs_q   <= divisor_i;
              shift_q <= dividend_i;
              p_q     <= '0;
              cnt_q   <= CntW'(N_DVD - 1);
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else begin
              // Zero divisor: publish the defined result at once, no iterations.
              quotient_q  <= '1;
              remainder_q <= dividend_i[N_DVS-1:0];
              div_zero_q  <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
        StRun: begin
          p_q     <= p_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - 1'b1;
          if (last_iter) begin
            quotient_q  <= shift_d;
            remainder_q <= p_d[N_DVS-1:0];
            div_zero_q  <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_binary_divider.sv
// Self-checking bench for binary_divider: a queue holds the expected result of
// every accepted request and a monitor pops it whenever done_o pulses.
module tb_binary_divider;

  localparam int unsigned NDvd = 8;
  localparam int unsigned NDvs = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NDvd-1:0] dividend;
  logic [NDvs-1:0] divisor;
  logic [NDvd-1:0] quotient;
  logic [NDvs-1:0] remainder;
  logic            busy;
  logic            done;
  logic            div_zero;

  binary_divider #(
    .N_DVD(NDvd),
    .N_DVS(NDvs)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .busy_o      (busy),
    .done_o      (done),
    .div_zero_o  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NDvd-1:0] q;
    logic [NDvs-1:0] r;
    logic            dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   done_cnt;
  int   last_done_cyc;
  int   prev_done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NDvd-1:0] a, input logic [NDvs-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a[NDvs-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = NDvd'(a / b);
      e.r  = NDvs'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_zero", 32'(div_zero), 32'(e.dz));
      end
    end
  end

  // Wait, from just after an accept edge, for the done pulse. Returns the number
  // of edges after the accept edge and how many cycles busy was seen high.
  task automatic wait_done(output int n, output int nb);
    bit seen;
    n    = 0;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic do_div(input logic [NDvd-1:0] a, input logic [NDvs-1:0] b);
    int n;
    int nb;
    sb.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    // Nonzero: done lands on the N_DVD-th edge after the accept edge.
    check("latency", 32'(n), (b == 0) ? 32'd0 : 32'(NDvd));
    check("busy_cycles", 32'(nb), (b == 0) ? 32'd0 : 32'(NDvd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int dc;
    n_vec = 0; n_err = 0; cyc = 0; done_cnt = 0;
    last_done_cyc = 0; prev_done_cyc = 0;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle", {quotient, remainder, busy, done, div_zero}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Directed vectors.
    do_div(8'h8F, 4'hB);
    do_div(8'd200, 4'd7);
    do_div(8'd5, 4'd9);
    do_div(8'd255, 4'd1);

    // Zero divisor followed by a normal division.
    do_div(8'h37, 4'd0);
    do_div(8'd100, 4'd10);

    // Multiply-then-divide round trip.
    for (int a = 1; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_div(NDvd'(a * b), NDvs'(b));
      end
    end

    // start during RUN with new operands is ignored.
    sb.push_back(model(8'h8F, 4'hB));
    dividend = 8'h8F; divisor = 4'hB; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, nb);
    repeat (12) @(posedge clk);
    #1 check("ignored_start_queue", 32'(sb.size()), 32'd0);

    // Back-to-back: start held through the done cycle.
    sb.push_back(model(8'd200, 4'd7));
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 dividend = 8'd143; divisor = 4'd11;
    sb.push_back(model(8'd143, 4'd11));
    wait_done(n, nb);
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n, nb);
    @(posedge clk);
    #1 check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'd9);

    // Asynchronous reset in the middle of a run.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_async", {quotient, remainder, busy, done, div_zero}, 32'd0);
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("rst_no_done", 32'(done_cnt - dc), 32'd0);
    do_div(8'd100, 4'd10);

    // Random vectors, zero divisor included.
    for (int i = 0; i < 20; i++) begin
      do_div(NDvd'($urandom_range(255, 0)), NDvs'($urandom_range(15, 0)));
    end

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
